// File: rtl/ram_erisim_hakemi.sv
// Two-requester round-robin arbiter and sequencer for the dual-port synchronous RAM.
// Writes take YAZ; reads take OKU1/OKU2, and the data returns to the requester that asked.
module ram_erisim_hakemi #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_istek,
    input  logic                  a_yaz,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_izin,
    output logic                  a_oku_gecerli,
    output logic [DATA_WIDTH-1:0] a_oku_data,
    input  logic                  b_istek,
    input  logic                  b_yaz,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_izin,
    output logic                  b_oku_gecerli,
    output logic [DATA_WIDTH-1:0] b_oku_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_yaz_addr,
    output logic [ADDR_WIDTH-1:0] ram_oku_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_oku_data
);

    localparam logic [1:0] BOSTA = 2'd0;
    localparam logic [1:0] YAZ   = 2'd1;
    localparam logic [1:0] OKU1  = 2'd2;
    localparam logic [1:0] OKU2  = 2'd3;

    localparam logic KIM_A = 1'b0;
    localparam logic KIM_B = 1'b1;

    logic [1:0]            state_q, state_d;
    logic                  son_kazanan_q, son_kazanan_d;
    logic                  islem_id_q, islem_id_d;
    logic [ADDR_WIDTH-1:0] islem_addr_q, islem_addr_d;
    logic [DATA_WIDTH-1:0] islem_data_q, islem_data_d;
    logic                  a_izin_q, a_izin_d;
    logic                  b_izin_q, b_izin_d;
    logic                  a_gecerli_q, a_gecerli_d;
    logic                  b_gecerli_q, b_gecerli_d;
    logic [DATA_WIDTH-1:0] a_oku_data_q, a_oku_data_d;
    logic [DATA_WIDTH-1:0] b_oku_data_q, b_oku_data_d;
    logic                  a_kazanir_s;
    logic                  b_kazanir_s;

    // On a tie the requester that did not win last time goes first.
    assign a_kazanir_s = a_istek && (!b_istek || (son_kazanan_q == KIM_B));
    assign b_kazanir_s = b_istek && !a_kazanir_s;

    // Next-state and transaction-latch logic.
    always_comb begin
        state_d       = state_q;
        son_kazanan_d = son_kazanan_q;
        islem_id_d    = islem_id_q;
        islem_addr_d  = islem_addr_q;
        islem_data_d  = islem_data_q;
        a_izin_d      = 1'b0;
        b_izin_d      = 1'b0;
        a_gecerli_d   = 1'b0;
        b_gecerli_d   = 1'b0;
        a_oku_data_d  = a_oku_data_q;
        b_oku_data_d  = b_oku_data_q;
        case (state_q)
            BOSTA: begin
                if (a_kazanir_s) begin
                    islem_id_d    = KIM_A;
                    islem_addr_d  = a_addr;
                    islem_data_d  = a_data;
                    son_kazanan_d = KIM_A;
                    a_izin_d      = 1'b1;
                    state_d       = a_yaz ? YAZ : OKU1;
                end else if (b_kazanir_s) begin
                    islem_id_d    = KIM_B;
                    islem_addr_d  = b_addr;
                    islem_data_d  = b_data;
                    son_kazanan_d = KIM_B;
                    b_izin_d      = 1'b1;
                    state_d       = b_yaz ? YAZ : OKU1;
                end else begin
                    state_d = BOSTA;
                end
            end
            YAZ:  state_d = BOSTA;
            OKU1: state_d = OKU2;
            OKU2: begin
                // RAM data is only trusted here, after the falling-edge latch in OKU1.
                if (islem_id_q == KIM_A) begin
                    a_oku_data_d = ram_oku_data;
                    a_gecerli_d  = 1'b1;
                end else begin
                    b_oku_data_d = ram_oku_data;
                    b_gecerli_d  = 1'b1;
                end
                state_d = BOSTA;
            end
            default: state_d = BOSTA;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOSTA;
            son_kazanan_q <= KIM_B;
            islem_id_q    <= KIM_A;
            islem_addr_q  <= {ADDR_WIDTH{1'b0}};
            islem_data_q  <= {DATA_WIDTH{1'b0}};
            a_izin_q      <= 1'b0;
            b_izin_q      <= 1'b0;
            a_gecerli_q   <= 1'b0;
            b_gecerli_q   <= 1'b0;
            a_oku_data_q  <= {DATA_WIDTH{1'b0}};
            b_oku_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            son_kazanan_q <= son_kazanan_d;
            islem_id_q    <= islem_id_d;
            islem_addr_q  <= islem_addr_d;
            islem_data_q  <= islem_data_d;
            a_izin_q      <= a_izin_d;
            b_izin_q      <= b_izin_d;
            a_gecerli_q   <= a_gecerli_d;
            b_gecerli_q   <= b_gecerli_d;
            a_oku_data_q  <= a_oku_data_d;
            b_oku_data_q  <= b_oku_data_d;
        end
    end

    // RAM control pins decoded from the state register.
    always_comb begin
        ram_cs = 1'b0;
        ram_we = 1'b0;
        ram_oe = 1'b0;
        case (state_q)
            BOSTA: begin
                ram_cs = 1'b0;
                ram_we = 1'b0;
                ram_oe = 1'b0;
            end
            YAZ: begin
                ram_cs = 1'b1;
                ram_we = 1'b1;
                ram_oe = 1'b0;
            end
            OKU1, OKU2: begin
                ram_cs = 1'b1;
                ram_we = 1'b0;
                ram_oe = 1'b1;
            end
            default: begin
                ram_cs = 1'b0;
                ram_we = 1'b0;
                ram_oe = 1'b0;
            end
        endcase
    end

    assign ram_yaz_addr  = islem_addr_q;
    assign ram_oku_addr  = islem_addr_q;
    assign ram_data      = islem_data_q;
    assign a_izin        = a_izin_q;
    assign b_izin        = b_izin_q;
    assign a_oku_gecerli = a_gecerli_q;
    assign b_oku_gecerli = b_gecerli_q;
    assign a_oku_data    = a_oku_data_q;
    assign b_oku_data    = b_oku_data_q;

endmodule

// File: tb/tb_ram_erisim_hakemi.sv
// Scoreboard bench for ram_erisim_hakemi with a behavioural model of the dual-port RAM.
// Stimulus pushes expected grants, RAM writes and read returns; a negedge monitor pops and compares.
module tb_ram_erisim_hakemi;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_istek, a_yaz, b_istek, b_yaz;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_izin, b_izin, a_oku_gecerli, b_oku_gecerli;
    logic [DW-1:0] a_oku_data, b_oku_data;
    logic          ram_cs, ram_we, ram_oe;
    logic [AW-1:0] ram_yaz_addr, ram_oku_addr;
    logic [DW-1:0] ram_data;
    wire  [DW-1:0] ram_oku_data;

    always #5 clk = ~clk;

    ram_erisim_hakemi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .a_istek(a_istek), .a_yaz(a_yaz), .a_addr(a_addr), .a_data(a_data),
        .a_izin(a_izin), .a_oku_gecerli(a_oku_gecerli), .a_oku_data(a_oku_data),
        .b_istek(b_istek), .b_yaz(b_yaz), .b_addr(b_addr), .b_data(b_data),
        .b_izin(b_izin), .b_oku_gecerli(b_oku_gecerli), .b_oku_data(b_oku_data),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_yaz_addr(ram_yaz_addr), .ram_oku_addr(ram_oku_addr),
        .ram_data(ram_data), .ram_oku_data(ram_oku_data)
    );

    // RAM model: write on rising edge, read latched on falling edge, tri-state output.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] oku_q = '0;
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge clk) if (ram_cs && ram_we) mem[ram_yaz_addr] <= ram_data;
    always @(negedge clk) if (ram_cs && !ram_we) oku_q <= mem[ram_oku_addr];
    assign ram_oku_data = (ram_cs && ram_oe && !ram_we) ? oku_q : {DW{1'bz}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event seen at cycle %0d, none expected", name, cyc);
    endfunction

    typedef struct {
        int            id;
        int            c;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    ev_t q_izin[$];
    ev_t q_yaz[$];
    ev_t q_oku[$];

    function automatic ev_t ev(input int id, input int c, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        ev_t e;
        e.id = id; e.c = c; e.addr = addr; e.data = data;
        return e;
    endfunction

    function automatic void see_izin(input int id);
        ev_t e;
        if (q_izin.size() == 0) unexpected(id == 0 ? "a_izin" : "b_izin");
        else begin
            e = q_izin.pop_front();
            chk("izin_who", id, e.id);
            chk("izin_cycle", cyc, e.c);
        end
    endfunction

    function automatic void see_oku(input int id, input logic [DW-1:0] d);
        ev_t e;
        if (q_oku.size() == 0) unexpected(id == 0 ? "a_oku_gecerli" : "b_oku_gecerli");
        else begin
            e = q_oku.pop_front();
            chk("oku_who", id, e.id);
            chk("oku_cycle", cyc, e.c);
            chk("oku_data", d, e.data);
        end
    endfunction

    function automatic void see_yaz();
        ev_t e;
        if (q_yaz.size() == 0) unexpected("ram_write");
        else begin
            e = q_yaz.pop_front();
            chk("yaz_cycle", cyc, e.c);
            chk("yaz_addr", ram_yaz_addr, e.addr);
            chk("yaz_data", ram_data, e.data);
        end
    endfunction

    // Monitor: every output event must match the head of its expectation queue.
    always @(negedge clk) begin
        if (a_izin) see_izin(0);
        if (b_izin) see_izin(1);
        if (ram_cs && ram_we) see_yaz();
        if (a_oku_gecerli) see_oku(0, a_oku_data);
        if (b_oku_gecerli) see_oku(1, b_oku_data);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Hold a request until its grant is seen, then drop it (bounded wait).
    task automatic do_req(input int id, input logic yaz, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic seen;
        seen = 1'b0;
        if (id == 0) begin a_istek = 1'b1; a_yaz = yaz; a_addr = addr; a_data = data; end
        else         begin b_istek = 1'b1; b_yaz = yaz; b_addr = addr; b_data = data; end
        for (int i = 0; i < 16 && !seen; i++) begin
            tick();
            seen = (id == 0) ? a_izin : b_izin;
        end
        if (id == 0) a_istek = 1'b0; else b_istek = 1'b0;
        chk("grant_wait", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int c;

    initial begin
        rst = 1'b1;
        a_istek = 1'b0; a_yaz = 1'b0; a_addr = '0; a_data = '0;
        b_istek = 1'b0; b_yaz = 1'b0; b_addr = '0; b_data = '0;
        repeat (3) tick();
        chk("rst_cs", ram_cs, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_oe", ram_oe, 1'b0);
        chk("rst_a_oku_data", a_oku_data, 16'h0000);
        chk("rst_b_oku_data", b_oku_data, 16'h0000);
        chk("rst_yaz_addr", ram_yaz_addr, 4'd0);
        rst = 1'b0;

        // A write 3 <- BEEF
        c = cyc;
        q_izin.push_back(ev(0, c + 1, 4'd0, 16'h0));
        q_yaz.push_back(ev(0, c + 1, 4'd3, 16'hBEEF));
        do_req(0, 1'b1, 4'd3, 16'hBEEF);
        chk("w_cs", ram_cs, 1'b1);
        chk("w_we", ram_we, 1'b1);
        chk("w_b_izin", b_izin, 1'b0);
        tick();
        chk("w_done_cs", ram_cs, 1'b0);

        // A read 3 -> BEEF, oe only in OKU1/OKU2
        c = cyc;
        q_izin.push_back(ev(0, c + 1, 4'd0, 16'h0));
        q_oku.push_back(ev(0, c + 3, 4'd0, 16'hBEEF));
        do_req(0, 1'b0, 4'd3, 16'h0);
        chk("r1_oe", ram_oe, 1'b1);
        chk("r1_we", ram_we, 1'b0);
        chk("r1_oku_addr", ram_oku_addr, 4'd3);
        tick();
        chk("r2_oe", ram_oe, 1'b1);
        tick();
        chk("r3_oe", ram_oe, 1'b0);
        chk("r3_a_data", a_oku_data, 16'hBEEF);

        // Reset, then simultaneous writes: A wins the first tie
        rst = 1'b1; tick(); rst = 1'b0;
        c = cyc;
        q_izin.push_back(ev(0, c + 1, 4'd0, 16'h0));
        q_yaz.push_back(ev(0, c + 1, 4'd1, 16'h1111));
        q_izin.push_back(ev(1, c + 3, 4'd0, 16'h0));
        q_yaz.push_back(ev(1, c + 3, 4'd2, 16'h2222));
        fork
            do_req(0, 1'b1, 4'd1, 16'h1111);
            do_req(1, 1'b1, 4'd2, 16'h2222);
        join
        repeat (2) tick();

        // Simultaneous reads: B won last, so A goes first; each gets its own data
        c = cyc;
        q_izin.push_back(ev(0, c + 1, 4'd0, 16'h0));
        q_oku.push_back(ev(0, c + 3, 4'd0, 16'h1111));
        q_izin.push_back(ev(1, c + 4, 4'd0, 16'h0));
        q_oku.push_back(ev(1, c + 6, 4'd0, 16'h2222));
        fork
            do_req(0, 1'b0, 4'd1, 16'h0);
            do_req(1, 1'b0, 4'd2, 16'h0);
        join
        repeat (4) tick();

        // B streams reads of 8 while A writes 8 four times: strict A,B alternation
        c = cyc;
        for (int k = 0; k < 4; k++) begin
            q_izin.push_back(ev(0, c + 1 + 5 * k, 4'd0, 16'h0));
            q_yaz.push_back(ev(0, c + 1 + 5 * k, 4'd8, 16'hA000 + 16'(k)));
            q_izin.push_back(ev(1, c + 3 + 5 * k, 4'd0, 16'h0));
            q_oku.push_back(ev(1, c + 5 + 5 * k, 4'd0, 16'hA000 + 16'(k)));
        end
        fork
            for (int k = 0; k < 4; k++) do_req(0, 1'b1, 4'd8, 16'hA000 + 16'(k));
            for (int j = 0; j < 4; j++) do_req(1, 1'b0, 4'd8, 16'h0);
        join
        repeat (4) tick();
        chk("alt_b_data", b_oku_data, 16'hA003);

        // Reset clears oku_data; B writes 5 then reset lands in OKU2 of its read
        rst = 1'b1; tick(); rst = 1'b0;
        c = cyc;
        q_izin.push_back(ev(1, c + 1, 4'd0, 16'h0));
        q_yaz.push_back(ev(1, c + 1, 4'd5, 16'h5555));
        do_req(1, 1'b1, 4'd5, 16'h5555);
        tick();
        c = cyc;
        q_izin.push_back(ev(1, c + 1, 4'd0, 16'h0));
        do_req(1, 1'b0, 4'd5, 16'h0);
        tick();
        chk("oku2_oe", ram_oe, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_cs", ram_cs, 1'b0);
        chk("abort_we", ram_we, 1'b0);
        chk("abort_oe", ram_oe, 1'b0);
        chk("abort_b_gecerli", b_oku_gecerli, 1'b0);
        chk("abort_b_data", b_oku_data, 16'h0000);
        tick();
        chk("abort_b_gecerli2", b_oku_gecerli, 1'b0);

        // Reset during YAZ still commits the write
        c = cyc;
        q_izin.push_back(ev(0, c + 1, 4'd0, 16'h0));
        q_yaz.push_back(ev(0, c + 1, 4'd7, 16'h1234));
        do_req(0, 1'b1, 4'd7, 16'h1234);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("yazrst_cs", ram_cs, 1'b0);
        c = cyc;
        q_izin.push_back(ev(0, c + 1, 4'd0, 16'h0));
        q_oku.push_back(ev(0, c + 3, 4'd0, 16'h1234));
        do_req(0, 1'b0, 4'd7, 16'h0);
        repeat (3) tick();

        // Idle: nothing selected, Z on the RAM bus never captured
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_cs", ram_cs, 1'b0);
            chk("idle_a_data", a_oku_data, 16'h1234);
            chk("idle_b_data", b_oku_data, 16'h0000);
        end

        tick();
        chk("left_izin", q_izin.size(), 32'd0);
        chk("left_yaz", q_yaz.size(), 32'd0);
        chk("left_oku", q_oku.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
